// File: rtl/ysyx_23060187_core_pkg.sv
// Shared constants for the multi-cycle RV32I/E core.
// Opcodes, FSM encoding and immediate selectors.
package ysyx_23060187_core_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_U,
    IMM_J
  } imm_sel_e;

  function automatic logic [31:0] imm_gen(
    input logic [31:0] ir,
    input imm_sel_e    sel
  );
    logic [31:0] imm;
    unique case (sel)
      IMM_I: imm = {{20{ir[31]}}, ir[31:20]};
      IMM_U: imm = {ir[31:12], 12'h000};
      IMM_J: imm = {{12{ir[31]}}, ir[19:12],
                    ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/ysyx_23060187_regfile_param.sv
// Register file: 2 async read ports, 1 sync write port.
// x0 reads zero; out-of-range indices read zero and never write.
module ysyx_23060187_regfile_param #(
  parameter int NR_REG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  output logic [31:0] rd1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  localparam int        AW = $clog2(NR_REG);
  localparam logic [5:0] NR = 6'(NR_REG);

  logic [31:0] rf [NR_REG];

  assign rd1 = (ra1 != 5'd0 && {1'b0, ra1} < NR)
             ? rf[ra1[AW-1:0]] : '0;
  assign rd2 = (ra2 != 5'd0 && {1'b0, ra2} < NR)
             ? rf[ra2[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_REG; i++) rf[i] <= '0;
    end else if (we && wa != 5'd0 && {1'b0, wa} < NR) begin
      rf[wa[AW-1:0]] <= wd;
    end
  end

endmodule

// File: rtl/ysyx_23060187_mcore.sv
// Multi-cycle RV32I/E subset core: FETCH -> EXEC -> FETCH,
// halting on ebreak or any illegal instruction.
module ysyx_23060187_mcore
  import ysyx_23060187_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          NR_REG   = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  output logic [31:0] ifu_addr,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_inst,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halt,
  output logic        illegal,
  output logic [31:0] halt_code
);

  localparam logic [5:0] NR = 6'(NR_REG);

  state_e      state;
  logic [31:0] ir;
  logic [31:0] rs1v, rs2v, wd, npc, tgt, imm_i;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2, ra2;
  logic        is_lui, is_auipc, is_jal, is_jalr;
  logic        is_addi, is_op, is_ebreak, op_ok;
  logic        legal, exec, we;

  function automatic logic rok(input logic [4:0] r);
    return {1'b0, r} < NR;
  endfunction

  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];

  assign is_lui    = opc == OPC_LUI;
  assign is_auipc  = opc == OPC_AUIPC;
  assign is_jal    = opc == OPC_JAL;
  assign is_jalr   = opc == OPC_JALR;
  assign is_addi   = opc == OPC_OP_IMM;
  assign is_op     = opc == OPC_OP;
  assign is_ebreak = opc == OPC_SYSTEM
                   && ir == INST_EBREAK;

  assign op_ok = is_op && ir[14:12] == 3'b000
              && (ir[31:25] == 7'h00
                  || ir[31:25] == 7'h20)
              && rok(rs1) && rok(rs2) && rok(rd);

  // Port 2 doubles as the a0 reader whenever we may halt.
  assign ra2   = op_ok ? rs2 : 5'd10;
  assign imm_i = imm_gen(ir, IMM_I);

  always_comb begin
    legal = 1'b0;
    wd    = '0;
    tgt   = '0;
    npc   = pc + 32'd4;
    unique case (1'b1)
      is_lui: begin
        legal = rok(rd);
        wd    = imm_gen(ir, IMM_U);
      end
      is_auipc: begin
        legal = rok(rd);
        wd    = pc + imm_gen(ir, IMM_U);
      end
      is_jal: begin
        tgt   = pc + imm_gen(ir, IMM_J);
        legal = rok(rd) && !tgt[1];
        wd    = pc + 32'd4;
        npc   = tgt;
      end
      is_jalr: begin
        tgt   = (rs1v + imm_i) & ~32'd1;
        legal = ir[14:12] == 3'b000
             && rok(rs1) && rok(rd) && !tgt[1];
        wd    = pc + 32'd4;
        npc   = tgt;
      end
      is_addi: begin
        legal = ir[14:12] == 3'b000
             && rok(rs1) && rok(rd);
        wd    = rs1v + imm_i;
      end
      is_op: begin
        legal = op_ok;
        wd    = ir[30] ? rs1v - rs2v : rs1v + rs2v;
      end
      is_ebreak: legal = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  assign exec          = state == S_EXEC && !rst;
  assign we            = exec && legal && !is_ebreak;
  assign retire        = exec && legal;
  assign ifu_req_valid = state == S_FETCH && !rst;
  assign ifu_addr      = pc;

  ysyx_23060187_regfile_param #(
    .NR_REG(NR_REG)
  ) u_rf (
    .clk(clk),
    .rst(rst),
    .ra1(rs1),
    .rd1(rs1v),
    .ra2(ra2),
    .rd2(rs2v),
    .we (we),
    .wa (rd),
    .wd (wd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      halt      <= 1'b0;
      illegal   <= 1'b0;
      halt_code <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (ifu_rsp_valid) begin
            ir    <= ifu_rsp_inst;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!legal) begin
            state     <= S_HALT;
            halt      <= 1'b1;
            illegal   <= 1'b1;
            halt_code <= rs2v;
          end else if (is_ebreak) begin
            state     <= S_HALT;
            halt      <= 1'b1;
            halt_code <= rs2v;
          end else begin
            pc    <= npc;
            state <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060187_mcore.sv
// Bench for ysyx_23060187_mcore: directed programs plus random
// programs checked against an instruction-level reference model.
module tb_ysyx_23060187_mcore;

  localparam logic [31:0] RPC  = 32'h8000_0000;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        rsp_v = 1'b0;
  logic [31:0] rsp_i = '0;
  logic        sel   = 1'b0;

  logic        req_a, ret_a, hlt_a, ill_a;
  logic [31:0] addr_a, pc_a, hc_a;
  logic        req_b, ret_b, hlt_b, ill_b;
  logic [31:0] addr_b, pc_b, hc_b;
  logic        req, ret, hlt, ill;
  logic [31:0] addr, pcv, hc;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] d_trace[$];
  logic [31:0] exp_trace[$];
  int          d_ret, m_ret;
  bit          m_ill;
  logic [31:0] m_code, m_pc;

  always #5 clk = ~clk;

  ysyx_23060187_mcore u_i (
    .clk(clk), .rst(rst),
    .ifu_req_valid(req_a), .ifu_addr(addr_a),
    .ifu_rsp_valid(rsp_v & ~sel),
    .ifu_rsp_inst(rsp_i),
    .pc(pc_a), .retire(ret_a), .halt(hlt_a),
    .illegal(ill_a), .halt_code(hc_a)
  );

  ysyx_23060187_mcore #(.NR_REG(16)) u_e (
    .clk(clk), .rst(rst),
    .ifu_req_valid(req_b), .ifu_addr(addr_b),
    .ifu_rsp_valid(rsp_v & sel),
    .ifu_rsp_inst(rsp_i),
    .pc(pc_b), .retire(ret_b), .halt(hlt_b),
    .illegal(ill_b), .halt_code(hc_b)
  );

  assign req  = sel ? req_b  : req_a;
  assign ret  = sel ? ret_b  : ret_a;
  assign hlt  = sel ? hlt_b  : hlt_a;
  assign ill  = sel ? ill_b  : ill_a;
  assign addr = sel ? addr_b : addr_a;
  assign pcv  = sel ? pc_b   : pc_a;
  assign hc   = sel ? hc_b   : hc_a;

  function automatic logic [31:0] e_i(input logic [11:0] imm,
    input logic [4:0] rs1, input logic [4:0] rd,
    input logic [6:0] opc);
    return {imm, rs1, 3'b000, rd, opc};
  endfunction

  function automatic logic [31:0] e_r(input logic [6:0] f7,
    input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] e_u(input logic [19:0] imm,
    input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] e_j(input logic [20:0] off,
    input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] fetchm(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [4:0] rr(input int nr);
    if ($urandom_range(15, 0) == 0) return 5'($urandom_range(31, 0));
    return 5'($urandom_range(nr - 1, 0));
  endfunction

  // Instruction-set-level reference: walks the program in mem.
  task automatic model_run(input int nr);
    logic [31:0] x [32];
    logic [31:0] p, ins, v, t, ii;
    logic [20:0] jo;
    int rd, r1, r2;
    bit bad;
    foreach (x[i]) x[i] = '0;
    p = RPC; m_ret = 0; m_ill = 0; m_code = '0;
    exp_trace.delete();
    for (int s = 0; s < 1000; s++) begin
      ins = fetchm(p);
      exp_trace.push_back(p);
      rd = int'(ins[11:7]);
      r1 = int'(ins[19:15]);
      r2 = int'(ins[24:20]);
      ii = {{20{ins[31]}}, ins[31:20]};
      jo = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      if (ins == EBRK) begin
        m_ret++; m_code = x[10]; break;
      end
      bad = 0; v = '0; t = p + 4;
      case (ins[6:0])
        7'h37: begin bad = rd >= nr; v = {ins[31:12], 12'h0}; end
        7'h17: begin bad = rd >= nr; v = p + {ins[31:12], 12'h0}; end
        7'h6f: begin
          bad = rd >= nr; v = p + 4;
          t = p + {{11{jo[20]}}, jo};
        end
        7'h67: begin
          bad = rd >= nr || r1 >= nr || ins[14:12] != 0;
          v = p + 4;
          t = (x[r1] + ii) & 32'hFFFF_FFFE;
        end
        7'h13: begin
          bad = rd >= nr || r1 >= nr || ins[14:12] != 0;
          v = x[r1] + ii;
        end
        7'h33: begin
          bad = rd >= nr || r1 >= nr || r2 >= nr
             || ins[14:12] != 0
             || (ins[31:25] != 0 && ins[31:25] != 32);
          v = (ins[31:25] == 32) ? x[r1] - x[r2] : x[r1] + x[r2];
        end
        default: bad = 1;
      endcase
      if (!bad && t % 4 != 0) bad = 1;
      if (bad) begin
        m_ill = 1; m_code = x[10]; break;
      end
      if (rd != 0) x[rd] = v;
      m_ret++;
      p = t;
    end
    m_pc = p;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rsp_v = 0; rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // Acts as instruction memory with up to maxw wait cycles.
  task automatic run_dut(input int maxw);
    int w, cyc;
    bit busy;
    logic [31:0] a0;
    d_ret = 0; d_trace.delete();
    busy = 0; w = 0; a0 = '0; cyc = 0;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (hlt) break;
      if (ret) d_ret++;
      rsp_v = 0;
      if (req) begin
        if (!busy) begin
          busy = 1; a0 = addr; w = $urandom_range(maxw, 0);
        end else begin
          n_vec++;
          if (addr !== a0) begin
            n_bad++;
            $display("FAIL addr_stable: got %h want %h", addr, a0);
          end
        end
        if (w == 0) begin
          rsp_v = 1; rsp_i = fetchm(addr);
          d_trace.push_back(addr); busy = 0;
        end else w--;
      end
    end
    rsp_v = 0;
    if (cyc >= 4000) begin
      n_vec++; n_bad++;
      $display("FAIL timeout: no halt in %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    @(negedge clk);
    rst = 1; rsp_v = 0;
    @(negedge clk);
    n_vec++;
    if (req !== 1'b0 || pcv !== RPC || ret !== 1'b0 || hlt !== 1'b0
        || ill !== 1'b0 || hc !== 32'h0) begin
      n_bad++;
      $display("FAIL reset: req=%b pc=%h ret=%b halt=%b ill=%b hc=%h",
               req, pcv, ret, hlt, ill, hc);
    end
    rst = 0;
    #1;
    n_vec++;
    if (req !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_req: got %b want 1", req);
    end
  endtask

  task automatic test_addi_add();
    sel = 0; mem.delete();
    mem[RPC]      = e_i(12'd5, 5'd0, 5'd1, 7'h13);
    mem[RPC + 4]  = e_i(12'hFFD, 5'd0, 5'd2, 7'h13);
    mem[RPC + 8]  = e_r(7'h00, 5'd2, 5'd1, 5'd10);
    mem[RPC + 12] = EBRK;
    apply_reset();
    run_dut(0);
    n_vec++;
    if (d_ret != 4 || hlt !== 1'b1 || ill !== 1'b0
        || hc !== 32'd2 || pcv !== RPC + 12) begin
      n_bad++;
      $display("FAIL addi_add: ret=%0d halt=%b ill=%b hc=%h pc=%h want 4 1 0 2 %h",
               d_ret, hlt, ill, hc, pcv, RPC + 12);
    end
  endtask

  task automatic test_jumps();
    sel = 0;
    for (int w = 0; w < 4; w++) begin
      mem.delete();
      mem[RPC]      = e_j(21'd8, 5'd1);
      mem[RPC + 8]  = e_i(12'd0, 5'd1, 5'd0, 7'h67);
      mem[RPC + 4]  = e_j(21'd12, 5'd0);
      mem[RPC + 16] = e_r(7'h00, 5'd0, 5'd1, 5'd10);
      mem[RPC + 20] = EBRK;
      apply_reset();
      run_dut(w);
      n_vec++;
      if (hc !== 32'h8000_0004 || d_ret != 5 || ill !== 1'b0
          || pcv !== RPC + 20) begin
        n_bad++;
        $display("FAIL jumps w=%0d: hc=%h ret=%0d ill=%b pc=%h want 80000004 5 0 %h",
                 w, hc, d_ret, ill, pcv, RPC + 20);
      end
      n_vec++;
      if (d_trace.size() != 5) begin
        n_bad++;
        $display("FAIL jump_trace_len: got %0d want 5", d_trace.size());
      end else if (d_trace[0] !== RPC || d_trace[1] !== RPC + 8
                   || d_trace[2] !== RPC + 4) begin
        n_bad++;
        $display("FAIL jump_trace: got %h %h %h want %h %h %h",
                 d_trace[0], d_trace[1], d_trace[2],
                 RPC, RPC + 8, RPC + 4);
      end
    end
  endtask

  task automatic test_wrap();
    sel = 0; mem.delete();
    mem[RPC]      = e_u(20'hFFFFF, 5'd5, 7'h37);
    mem[RPC + 4]  = e_i(12'h7FF, 5'd5, 5'd5, 7'h13);
    mem[RPC + 8]  = e_r(7'h00, 5'd0, 5'd5, 5'd10);
    mem[RPC + 12] = EBRK;
    apply_reset();
    run_dut(2);
    n_vec++;
    if (hc !== 32'hFFFF_F7FF || ill !== 1'b0) begin
      n_bad++;
      $display("FAIL lui_addi: hc=%h ill=%b want fffff7ff 0", hc, ill);
    end
    mem.delete();
    mem[RPC]     = e_i(12'hFFF, 5'd0, 5'd6, 7'h13);
    mem[RPC + 4] = e_r(7'h20, 5'd6, 5'd0, 5'd10);
    mem[RPC + 8] = EBRK;
    apply_reset();
    run_dut(1);
    n_vec++;
    if (hc !== 32'd1 || d_ret != 3) begin
      n_bad++;
      $display("FAIL sub_wrap: hc=%h ret=%0d want 1 3", hc, d_ret);
    end
  endtask

  task automatic test_illegal();
    sel = 0; mem.delete();
    mem[RPC]     = e_i(12'd33, 5'd0, 5'd10, 7'h13);
    mem[RPC + 4] = e_r(7'h01, 5'd2, 5'd1, 5'd10);
    apply_reset();
    run_dut(1);
    n_vec++;
    if (hlt !== 1'b1 || ill !== 1'b1 || hc !== 32'd33
        || pcv !== RPC + 4 || d_ret != 1) begin
      n_bad++;
      $display("FAIL illegal: halt=%b ill=%b hc=%h pc=%h ret=%0d want 1 1 21 %h 1",
               hlt, ill, hc, pcv, d_ret, RPC + 4);
    end
    for (int k = 0; k < 6; k++) begin
      rsp_v = 1; rsp_i = e_i(12'd1, 5'd0, 5'd10, 7'h13);
      @(negedge clk);
      n_vec++;
      if (ret !== 1'b0 || req !== 1'b0 || hlt !== 1'b1 || ill !== 1'b1
          || pcv !== RPC + 4 || hc !== 32'd33) begin
        n_bad++;
        $display("FAIL halt_sticky: ret=%b req=%b halt=%b ill=%b pc=%h hc=%h",
                 ret, req, hlt, ill, pcv, hc);
      end
    end
    rsp_v = 0;
  endtask

  task automatic test_rv32e();
    sel = 1; mem.delete();
    mem[RPC]     = e_i(12'd7, 5'd0, 5'd10, 7'h13);
    mem[RPC + 4] = e_i(12'd1, 5'd0, 5'd16, 7'h13);
    apply_reset();
    run_dut(0);
    n_vec++;
    if (hlt !== 1'b1 || ill !== 1'b1 || hc !== 32'd7
        || pcv !== RPC + 4 || d_ret != 1) begin
      n_bad++;
      $display("FAIL rv32e: halt=%b ill=%b hc=%h pc=%h ret=%0d want 1 1 7 %h 1",
               hlt, ill, hc, pcv, d_ret, RPC + 4);
    end
    sel = 0;
  endtask

  task automatic test_reset_mid();
    sel = 0; mem.delete();
    apply_reset();
    @(negedge clk);
    rsp_v = 1; rsp_i = e_i(12'd9, 5'd0, 5'd3, 7'h13);
    @(negedge clk);
    rsp_v = 0; rst = 1;
    #1;
    n_vec++;
    if (ret !== 1'b0 || req !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_exec: ret=%b req=%b want 0 0", ret, req);
    end
    @(negedge clk);
    rsp_v = 1; rsp_i = e_i(12'd5, 5'd0, 5'd10, 7'h13);
    #1;
    n_vec++;
    if (pcv !== RPC || req !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_hold: pc=%h req=%b want %h 0", pcv, req, RPC);
    end
    @(negedge clk);
    rst = 0; rsp_v = 0;
    #1;
    n_vec++;
    if (req !== 1'b1) begin
      n_bad++; $display("FAIL rst_resume: req=%b want 1", req);
    end
    mem[RPC]     = e_r(7'h00, 5'd0, 5'd3, 5'd10);
    mem[RPC + 4] = EBRK;
    run_dut(1);
    n_vec++;
    if (hc !== 32'd0 || d_ret != 2 || ill !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_abort: x3=%h ret=%0d ill=%b want 0 2 0", hc, d_ret, ill);
    end
  endtask

  task automatic gen_prog(input int nr);
    logic [31:0] a;
    int n;
    mem.delete();
    a = RPC;
    n = $urandom_range(12, 4);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(9, 0))
        0, 1, 2: mem[a] = e_i(12'($urandom), rr(nr), rr(nr), 7'h13);
        3, 4: mem[a] = e_r(7'h00, rr(nr), rr(nr), rr(nr));
        5: mem[a] = e_r(7'h20, rr(nr), rr(nr), rr(nr));
        6: mem[a] = e_u(20'($urandom), rr(nr), 7'h37);
        7: mem[a] = e_u(20'($urandom), rr(nr), 7'h17);
        8: begin
          mem[a] = e_j(21'd8, rr(nr));
          a += 4;
          mem[a] = 32'h0;
        end
        default: mem[a] = e_r(($urandom_range(3, 0) == 0) ? 7'h01 : 7'h00,
                              rr(nr), rr(nr), rr(nr));
      endcase
      a += 4;
    end
    mem[a]     = e_r(7'h00, rr(nr), 5'd0, 5'd10);
    mem[a + 4] = EBRK;
  endtask

  task automatic test_random();
    int nr;
    for (int it = 0; it < 40; it++) begin
      sel = 1'($urandom_range(1, 0));
      nr  = sel ? 16 : 32;
      gen_prog(nr);
      model_run(nr);
      apply_reset();
      run_dut($urandom_range(3, 0));
      n_vec++;
      if (d_ret != m_ret || hlt !== 1'b1 || ill !== m_ill
          || hc !== m_code || pcv !== m_pc) begin
        n_bad++;
        $display("FAIL random[%0d]: ret=%0d/%0d halt=%b ill=%b/%b hc=%h/%h pc=%h/%h",
                 it, d_ret, m_ret, hlt, ill, m_ill, hc, m_code, pcv, m_pc);
      end
      n_vec++;
      if (d_trace.size() != exp_trace.size()) begin
        n_bad++;
        $display("FAIL random_trace_len[%0d]: got %0d want %0d",
                 it, d_trace.size(), exp_trace.size());
      end else begin
        foreach (d_trace[j]) begin
          if (d_trace[j] !== exp_trace[j]) begin
            n_bad++;
            $display("FAIL random_trace[%0d.%0d]: got %h want %h",
                     it, j, d_trace[j], exp_trace[j]);
            break;
          end
        end
      end
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_addi_add();
    test_jumps();
    test_wrap();
    test_illegal();
    test_rv32e();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
